// File: rtl/jogo_pkg.sv
// Shared definitions for the circuito_jogo input path: button count, position-code
// width and the capture FSM state encodings.
`timescale 1ns/1ps

package jogo_pkg;

    localparam int N_BOTOES = 9;
    localparam int JOGADA_W = 4;

    localparam logic [JOGADA_W-1:0] SEM_JOGADA = 4'd0;

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        FILTRA        = 3'd1,
        REGISTRA      = 3'd2,
        ERRO          = 3'd3,
        ESPERA_SOLTAR = 3'd4
    } estado_t;

endpackage

// File: rtl/codificador_botoes.sv
// Combinational button encoder: one-hot 9-bit button vector to position code 1..9.
// Returns SEM_JOGADA when no button is pressed or when more than one is (flagged by multiplo).
`timescale 1ns/1ps

module codificador_botoes
    import jogo_pkg::*;
(
    input  logic [N_BOTOES-1:0] botoes,
    output logic [JOGADA_W-1:0] codigo,
    output logic                multiplo
);

    logic [JOGADA_W-1:0] contagem;
    logic [JOGADA_W-1:0] indice;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        contagem = '0;
        indice   = SEM_JOGADA;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (botoes[i]) begin
                contagem = contagem + JOGADA_W'(1);
                indice   = JOGADA_W'(i + 1);
            end
        end
        multiplo = (contagem > JOGADA_W'(1));
        codigo   = multiplo ? SEM_JOGADA : indice;
    end

endmodule

// File: rtl/captura_jogada.sv
// Button capture unit: debounces raw presses, rejects multi-button presses and emits one
// tem_jogada pulse per physical press. Optional macro BOTOES_SINC_EN adds a 2-flop input synchronizer.
`timescale 1ns/1ps

module captura_jogada
    import jogo_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 2
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic                limpa,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [JOGADA_W-1:0] jogada,
    output logic                tem_jogada,
    output logic                erro_multiplo,
    output logic [2:0]          db_estado
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CNT_W-1:0] CNT_ALVO = CNT_W'(DEBOUNCE_CICLOS);

    logic [N_BOTOES-1:0] entrada;

`ifdef BOTOES_SINC_EN
    logic [N_BOTOES-1:0] sinc_a;
    logic [N_BOTOES-1:0] sinc_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_a <= '0;
            sinc_b <= '0;
        end else begin
            sinc_a <= botoes;
            sinc_b <= sinc_a;
        end
    end

    assign entrada = sinc_b;
`else
    assign entrada = botoes;
`endif

    estado_t             estado, estado_prox;
    logic [CNT_W-1:0]    cnt, cnt_prox, cnt_inc;
    logic [N_BOTOES-1:0] amostra, amostra_prox;
    logic [JOGADA_W-1:0] codigo;
    logic                multiplo;
    logic                carrega;

    // While filtering, entrada equals amostra on every accepting edge, so one encoder suffices.
    codificador_botoes u_codificador (
        .botoes   (entrada),
        .codigo   (codigo),
        .multiplo (multiplo)
    );

    assign cnt_inc = (cnt == CNT_ALVO) ? cnt : cnt + CNT_W'(1);

    // NOTE: state registers use non-blocking assignments; the combinational block below uses blocking ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= OCIOSO;
            cnt     <= '0;
            amostra <= '0;
        end else begin
            estado  <= estado_prox;
            cnt     <= cnt_prox;
            amostra <= amostra_prox;
        end
    end

    always_comb begin
        estado_prox   = estado;
        cnt_prox      = cnt;
        amostra_prox  = amostra;
        carrega       = 1'b0;
        tem_jogada    = 1'b0;
        erro_multiplo = 1'b0;

        unique case (estado)
            OCIOSO: begin
                if (habilita && entrada != '0) begin
                    amostra_prox = entrada;
                    cnt_prox     = CNT_W'(1);
                    if (CNT_ALVO == CNT_W'(1)) begin
                        estado_prox = multiplo ? ERRO : REGISTRA;
                        carrega     = !multiplo;
                    end else begin
                        estado_prox = FILTRA;
                    end
                end
            end

            FILTRA: begin
                // A glitch, a change of button or loss of habilita restarts the filter.
                if (!habilita || entrada != amostra) begin
                    estado_prox = OCIOSO;
                    cnt_prox    = '0;
                end else if (cnt_inc == CNT_ALVO) begin
                    estado_prox = multiplo ? ERRO : REGISTRA;
                    carrega     = !multiplo;
                    cnt_prox    = '0;
                end else begin
                    cnt_prox = cnt_inc;
                end
            end

            REGISTRA: begin
                tem_jogada  = 1'b1;
                estado_prox = ESPERA_SOLTAR;
                cnt_prox    = '0;
            end

            ERRO: begin
                erro_multiplo = 1'b1;
                estado_prox   = ESPERA_SOLTAR;
                cnt_prox      = '0;
            end

            ESPERA_SOLTAR: begin
                // habilita is ignored here so a held button cannot re-trigger.
                if (entrada != '0) begin
                    cnt_prox = '0;
                end else if (cnt_inc == CNT_ALVO) begin
                    estado_prox = OCIOSO;
                    cnt_prox    = '0;
                end else begin
                    cnt_prox = cnt_inc;
                end
            end

            default: begin
                estado_prox = OCIOSO;
                cnt_prox    = '0;
            end
        endcase
    end

    // A load on entry to REGISTRA takes priority over limpa.
    always_ff @(posedge clock) begin
        if (reset) begin
            jogada <= SEM_JOGADA;
        end else if (carrega) begin
            jogada <= codigo;
        end else if (limpa) begin
            jogada <= SEM_JOGADA;
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_captura_jogada.sv
// Self-checking bench for captura_jogada: directed steps from the test plan followed by
// randomized presses checked against a press-level reference model.
`timescale 1ns/1ps

module tb_captura_jogada;
    import jogo_pkg::*;

    localparam int D = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic                habilita;
    logic                limpa;
    logic [N_BOTOES-1:0] botoes;
    logic [JOGADA_W-1:0] jogada;
    logic                tem_jogada;
    logic                erro_multiplo;
    logic [2:0]          db_estado;

    int n_asserts = 0;
    int n_fails   = 0;

    captura_jogada #(.DEBOUNCE_CICLOS(D)) dut (
        .clock         (clock),
        .reset         (reset),
        .habilita      (habilita),
        .limpa         (limpa),
        .botoes        (botoes),
        .jogada        (jogada),
        .tem_jogada    (tem_jogada),
        .erro_multiplo (erro_multiplo),
        .db_estado     (db_estado)
    );

    always #10 clock = ~clock;

    // Output monitor: samples 1 ns after each rising edge.
    int                  cyc      = 0;
    int                  n_tem    = 0;
    int                  n_erro   = 0;
    int                  n_espera = 0;
    int                  tem_cyc  = -1;
    int                  erro_cyc = -1;
    logic [JOGADA_W-1:0] jog_pulso = '0;

    always @(posedge clock) begin
        cyc++;
        #1;
        if (tem_jogada === 1'b1) begin
            n_tem++;
            tem_cyc   = cyc;
            jog_pulso = jogada;
        end
        if (erro_multiplo === 1'b1) begin
            n_erro++;
            erro_cyc = cyc;
        end
        if (db_estado === 3'd4) n_espera++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference position code: bit i set means button i+1.
    function automatic logic [JOGADA_W-1:0] codigo_ref(input logic [N_BOTOES-1:0] b);
        for (int i = 0; i < N_BOTOES; i++)
            if (b[i]) return JOGADA_W'(i + 1);
        return SEM_JOGADA;
    endfunction

    logic [JOGADA_W-1:0] modelo_jogada;

    // One physical press: pattern p held for L sampling edges with habilita=hab, then R idle cycles.
    task automatic pressiona(input string tag, input logic [N_BOTOES-1:0] p, input int L,
                             input logic hab, input int R);
        int t0, e0, inicio;
        bit aceito, simples;
        @(negedge clock);
        t0       = n_tem;
        e0       = n_erro;
        inicio   = cyc + 1;
        habilita = hab;
        botoes   = p;
        repeat (L) @(negedge clock);
        botoes = '0;
        repeat (R) @(negedge clock);
        habilita = 1'b1;

        aceito  = hab && (L >= D);
        simples = ($countones(p) == 1);
        check({tag, " tem_jogada pulses"}, n_tem - t0, (aceito && simples) ? 1 : 0);
        check({tag, " erro_multiplo pulses"}, n_erro - e0, (aceito && !simples) ? 1 : 0);
        if (aceito && simples) begin
            modelo_jogada = codigo_ref(p);
            check({tag, " jogada during pulse"}, jog_pulso, modelo_jogada);
            check({tag, " pulse latency"}, tem_cyc - inicio, D - 1);
        end
        if (aceito && !simples)
            check({tag, " erro latency"}, erro_cyc - inicio, D - 1);
        check({tag, " jogada after press"}, jogada, modelo_jogada);
        check({tag, " back in OCIOSO"}, db_estado, 3'd0);
    endtask

    initial begin
        int t0, e0, s0;
        logic [N_BOTOES-1:0] p;

        reset         = 1'b1;
        habilita      = 1'b0;
        limpa         = 1'b0;
        botoes        = '0;
        modelo_jogada = SEM_JOGADA;

        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("idle db_estado", db_estado, 3'd0);
            check("idle jogada", jogada, SEM_JOGADA);
            check("idle tem_jogada", tem_jogada, 1'b0);
            check("idle erro_multiplo", erro_multiplo, 1'b0);
        end

        habilita = 1'b1;
        s0 = n_espera;
        pressiona("button4", 9'b000001000, 2, 1'b1, 5);
        check("button4 ESPERA_SOLTAR cycles", n_espera - s0, D);

        pressiona("button5 held", 9'b000010000, 20, 1'b1, 5);
        pressiona("multi 0x003", 9'b000000011, 3, 1'b1, 5);
        pressiona("glitch", 9'b000000010, 1, 1'b1, 4);
        pressiona("habilita low", 9'b000001000, 5, 1'b0, 4);

        @(negedge clock);
        limpa = 1'b1;
        @(negedge clock);
        limpa = 1'b0;
        modelo_jogada = SEM_JOGADA;
        check("limpa clears jogada", jogada, SEM_JOGADA);
        check("limpa keeps FSM", db_estado, 3'd0);

        pressiona("button2", 9'b000000010, 2, 1'b1, 5);

        // limpa asserted on the same edge that loads jogada: the load must win
        @(negedge clock);
        t0     = n_tem;
        botoes = 9'b001000000;
        @(negedge clock);
        limpa = 1'b1;
        @(negedge clock);
        limpa  = 1'b0;
        botoes = '0;
        repeat (5) @(negedge clock);
        modelo_jogada = 4'd7;
        check("limpa vs load pulses", n_tem - t0, 1);
        check("limpa vs load jogada", jogada, modelo_jogada);

        // reset while filtering discards the press and clears jogada
        @(negedge clock);
        t0     = n_tem;
        e0     = n_erro;
        botoes = 9'b100000000;
        @(negedge clock);
        check("in FILTRA before reset", db_estado, 3'd1);
        reset = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        botoes = '0;
        check("reset during FILTRA state", db_estado, 3'd0);
        repeat (4) @(negedge clock);
        modelo_jogada = SEM_JOGADA;
        check("reset during FILTRA no pulse", n_tem - t0, 0);
        check("reset during FILTRA no erro", n_erro - e0, 0);
        check("reset during FILTRA jogada", jogada, modelo_jogada);

        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 1) == 1)
                p = N_BOTOES'(1) << $urandom_range(0, N_BOTOES - 1);
            else
                p = N_BOTOES'($urandom_range(1, 511));
            pressiona($sformatf("rnd%0d", k), p, int'($urandom_range(1, 5)),
                      ($urandom_range(0, 4) != 0), int'($urandom_range(5, 8)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
